fpga_reset_sequencer: RTL and testbench

Board-level reset and power sequencer for the FPGA PULPissimo top. It synchronises and debounces the reset push-button, waits for the clock to be stable, and powers the on-board SD card through its active-low supply enable. It then holds the SoC in reset for a fixed time, latches the boot-select strap, and releases the SoC. It sits between the board pads/clock buffer and the pulpissimo instance's pad_reset_n, pad_jtag_trst and pad_bootsel inputs.

---
 rtl/fpga_reset_sequencer.sv | 159 +++++++++++++++
 tb/tb_fpga_reset_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/fpga_reset_sequencer.sv
// Board reset/power sequencer: syncs inputs, debounces the reset button, powers the SD card,
// holds the SoC in reset, latches bootsel. Optional macro SDIO_PWR_CYCLE_EN power-cycles SD on button reset.
module fpga_reset_sequencer #(
  parameter int CNT_WIDTH       = 20,
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int SD_PWR_CYCLES   = 200000,
  parameter int RST_HOLD_CYCLES = 1000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clk_locked_i,
  input  logic       btn_reset_ni,
  input  logic       bootsel_i,
  output logic       soc_rst_no,
  output logic       jtag_trst_no,
  output logic       sdio_pwr_en_no,
  output logic       bootsel_o,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    PWR_UP    = 3'd1,
    HOLD      = 3'd2,
    RUN       = 3'd3,
    BTN_RST   = 3'd4
  } state_e;

  localparam logic [CNT_WIDTH-1:0] DB_LAST   = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] SD_LAST   = CNT_WIDTH'(SD_PWR_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(RST_HOLD_CYCLES - 1);

  logic [1:0]           lock_sync_q, lock_sync_d;
  logic [1:0]           btn_sync_q, btn_sync_d;
  logic [1:0]           boot_sync_q, boot_sync_d;
  logic                 btn_db_q, btn_db_d;
  logic [CNT_WIDTH-1:0] db_cnt_q, db_cnt_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  state_e               state_q, state_d;
  logic                 soc_rst_q, soc_rst_d;
  logic                 jtag_trst_q, jtag_trst_d;
  logic                 sd_pwr_q, sd_pwr_d;
  logic                 bootsel_q, bootsel_d;
  logic                 locked;

  assign locked = lock_sync_q[1];

  always_comb begin
    lock_sync_d = {lock_sync_q[0], clk_locked_i};
    btn_sync_d  = {btn_sync_q[0], btn_reset_ni};
    boot_sync_d = {boot_sync_q[0], bootsel_i};

    // The debounce run restarts whenever the synced button agrees with the accepted state.
    btn_db_d = btn_db_q;
    db_cnt_d = '0;
    if (btn_sync_q[1] != btn_db_q) begin
      if (db_cnt_q == DB_LAST) btn_db_d = btn_sync_q[1];
      else                     db_cnt_d = db_cnt_q + 1'b1;
    end

    state_d   = state_q;
    cnt_d     = cnt_q;
    bootsel_d = bootsel_q;
    if (state_q != WAIT_LOCK && !locked) begin
      state_d = WAIT_LOCK;
      cnt_d   = '0;
    end else begin
      case (state_q)
        WAIT_LOCK: if (locked) begin
          state_d = PWR_UP;
          cnt_d   = SD_LAST;
        end
        PWR_UP: if (cnt_q == '0) begin
          state_d = HOLD;
          cnt_d   = HOLD_LAST;
        end else cnt_d = cnt_q - 1'b1;
        HOLD: if (cnt_q == '0) begin
          state_d   = RUN;
          bootsel_d = boot_sync_q[1];
        end else cnt_d = cnt_q - 1'b1;
        RUN: if (!btn_db_q) state_d = BTN_RST;
        BTN_RST: if (btn_db_q) begin
`ifdef SDIO_PWR_CYCLE_EN
          state_d = PWR_UP;
          cnt_d   = SD_LAST;
`else
          state_d = HOLD;
          cnt_d   = HOLD_LAST;
`endif
        end
        default: begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end
      endcase
    end

    // Outputs decode the next state so they flip together with state_o.
    soc_rst_d   = 1'b0;
    jtag_trst_d = 1'b0;
    sd_pwr_d    = 1'b1;
    case (state_d)
      PWR_UP: sd_pwr_d = 1'b0;
      HOLD: begin
        jtag_trst_d = 1'b1;
        sd_pwr_d    = 1'b0;
      end
      RUN: begin
        soc_rst_d   = 1'b1;
        jtag_trst_d = 1'b1;
        sd_pwr_d    = 1'b0;
      end
      BTN_RST: begin
        jtag_trst_d = 1'b1;
`ifdef SDIO_PWR_CYCLE_EN
        sd_pwr_d    = 1'b1;
`else
        sd_pwr_d    = 1'b0;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_sync_q <= 2'b00;
      btn_sync_q  <= 2'b11;
      boot_sync_q <= 2'b00;
      btn_db_q    <= 1'b1;
      db_cnt_q    <= '0;
      cnt_q       <= '0;
      state_q     <= WAIT_LOCK;
      soc_rst_q   <= 1'b0;
      jtag_trst_q <= 1'b0;
      sd_pwr_q    <= 1'b1;
      bootsel_q   <= 1'b0;
    end else begin
      lock_sync_q <= lock_sync_d;
      btn_sync_q  <= btn_sync_d;
      boot_sync_q <= boot_sync_d;
      btn_db_q    <= btn_db_d;
      db_cnt_q    <= db_cnt_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      soc_rst_q   <= soc_rst_d;
      jtag_trst_q <= jtag_trst_d;
      sd_pwr_q    <= sd_pwr_d;
      bootsel_q   <= bootsel_d;
    end
  end

  assign soc_rst_no     = soc_rst_q;
  assign jtag_trst_no   = jtag_trst_q;
  assign sdio_pwr_en_no = sd_pwr_q;
  assign bootsel_o      = bootsel_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_fpga_reset_sequencer.sv
// Bench for fpga_reset_sequencer: phase/duration reference model checked every cycle,
// directed literal checks for the main sequences, then randomized pad activity.
module tb_fpga_reset_sequencer;
  localparam int CW   = 8;
  localparam int DEB  = 4;
  localparam int SDC  = 8;
  localparam int HLD  = 5;

  localparam int P_WAIT = 0;
  localparam int P_PWR  = 1;
  localparam int P_HOLD = 2;
  localparam int P_RUN  = 3;
  localparam int P_BTN  = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       lock_i = 1'b0;
  logic       btn_i = 1'b1;
  logic       boot_i = 1'b0;
  logic       soc_rst_no, jtag_trst_no, sdio_pwr_en_no, bootsel_o;
  logic [2:0] state_o;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  fpga_reset_sequencer #(
    .CNT_WIDTH(CW), .DEBOUNCE_CYCLES(DEB), .SD_PWR_CYCLES(SDC), .RST_HOLD_CYCLES(HLD)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .clk_locked_i(lock_i), .btn_reset_ni(btn_i),
    .bootsel_i(boot_i), .soc_rst_no(soc_rst_no), .jtag_trst_no(jtag_trst_no),
    .sdio_pwr_en_no(sdio_pwr_en_no), .bootsel_o(bootsel_o), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // Reference model: pads seen through 2-cycle delay lines, phases with elapsed-cycle durations.
  logic [1:0] m_lk = 2'b00, m_bt = 2'b11, m_bs = 2'b00;
  logic       m_db = 1'b1, m_boot = 1'b0;
  int         m_run = 0, m_phase = P_WAIT, m_elapsed = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_lk = 2'b00; m_bt = 2'b11; m_bs = 2'b00;
      m_db = 1'b1; m_boot = 1'b0; m_run = 0; m_phase = P_WAIT; m_elapsed = 0;
    end else begin
      if (m_phase != P_WAIT && !m_lk[1]) begin
        m_phase = P_WAIT; m_elapsed = 0;
      end else begin
        case (m_phase)
          P_WAIT: if (m_lk[1]) begin m_phase = P_PWR; m_elapsed = 0; end
          P_PWR: begin
            if (m_elapsed + 1 == SDC) begin m_phase = P_HOLD; m_elapsed = 0; end
            else m_elapsed++;
          end
          P_HOLD: begin
            if (m_elapsed + 1 == HLD) begin m_phase = P_RUN; m_elapsed = 0; m_boot = m_bs[1]; end
            else m_elapsed++;
          end
          P_RUN: if (!m_db) m_phase = P_BTN;
          default: if (m_db) begin
`ifdef SDIO_PWR_CYCLE_EN
            m_phase = P_PWR;
`else
            m_phase = P_HOLD;
`endif
            m_elapsed = 0;
          end
        endcase
      end
      if (m_bt[1] != m_db) begin
        m_run++;
        if (m_run == DEB) begin m_db = m_bt[1]; m_run = 0; end
      end else m_run = 0;
      m_lk = {m_lk[0], lock_i};
      m_bt = {m_bt[0], btn_i};
      m_bs = {m_bs[0], boot_i};
    end
  end

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      logic e_soc, e_jtag, e_sd;
      e_soc = 1'b0; e_jtag = 1'b0; e_sd = 1'b1;
      case (m_phase)
        P_PWR:  e_sd = 1'b0;
        P_HOLD: begin e_jtag = 1'b1; e_sd = 1'b0; end
        P_RUN:  begin e_soc = 1'b1; e_jtag = 1'b1; e_sd = 1'b0; end
        P_BTN: begin
          e_jtag = 1'b1;
`ifdef SDIO_PWR_CYCLE_EN
          e_sd = 1'b1;
`else
          e_sd = 1'b0;
`endif
        end
        default: ;
      endcase
      cmp("model_state", int'(state_o), m_phase);
      cmp("model_soc_rst", int'(soc_rst_no), int'(e_soc));
      cmp("model_jtag_trst", int'(jtag_trst_no), int'(e_jtag));
      cmp("model_sd_pwr", int'(sdio_pwr_en_no), int'(e_sd));
      cmp("model_bootsel", int'(bootsel_o), int'(m_boot));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string name, input int st, input int soc, input int jt, input int sd);
    cmp({name, "_state"}, int'(state_o), st);
    cmp({name, "_soc"}, int'(soc_rst_no), soc);
    cmp({name, "_jtag"}, int'(jtag_trst_no), jt);
    cmp({name, "_sd"}, int'(sdio_pwr_en_no), sd);
  endtask

`ifdef SDIO_PWR_CYCLE_EN
  localparam int BTN_SD = 1;
`else
  localparam int BTN_SD = 0;
`endif

  initial begin
    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    lock_i = 1'b1; btn_i = 1'b1; boot_i = 1'b1;
    step(3);
    chk_out("reset", 0, 0, 0, 1);
    cmp("reset_bootsel", int'(bootsel_o), 0);
    rst_n = 1'b1;

    // Power-on sequence
    step(2); chk_out("sync_wait", 0, 0, 0, 1);
    step(1); chk_out("pwr_entry", 1, 0, 0, 0);
    step(7); chk_out("pwr_last", 1, 0, 0, 0);
    step(1); chk_out("hold_entry", 2, 0, 1, 0);
    step(4); chk_out("hold_last", 2, 0, 1, 0);
    step(1); chk_out("run_entry", 3, 1, 1, 0);
    cmp("run_bootsel1", int'(bootsel_o), 1);

    // Short glitch rejected
    btn_i = 1'b0; step(3); btn_i = 1'b1;
    step(12); chk_out("glitch_ignored", 3, 1, 1, 0);

    // Long press: soc reset falls 7 cycles after the pad edge
    btn_i = 1'b0;
    step(6); chk_out("press_pre", 3, 1, 1, 0);
    step(1); chk_out("press_btn", 4, 0, 1, BTN_SD);
    step(3);
    btn_i = 1'b1; boot_i = 1'b0;
    step(6); chk_out("release_pre", 4, 0, 1, BTN_SD);
`ifdef SDIO_PWR_CYCLE_EN
    step(1); chk_out("release_pwr", 1, 0, 0, 0);
    step(8); chk_out("release_hold", 2, 0, 1, 0);
    step(5); chk_out("release_run", 3, 1, 1, 0);
`else
    step(1); chk_out("release_hold", 2, 0, 1, 0);
    step(4); chk_out("release_hold_last", 2, 0, 1, 0);
    step(1); chk_out("release_run", 3, 1, 1, 0);
`endif
    cmp("run_bootsel0", int'(bootsel_o), 0);
    boot_i = 1'b1; step(5);
    cmp("bootsel_held_in_run", int'(bootsel_o), 0);

    // Clock loss in RUN, then again at the last HOLD cycle (beats counter expiry)
    lock_i = 1'b0; step(3); chk_out("loss_run", 0, 0, 0, 1);
    lock_i = 1'b1; step(3); chk_out("relock_pwr", 1, 0, 0, 0);
    step(8); chk_out("relock_hold", 2, 0, 1, 0);
    step(2); lock_i = 1'b0;
    step(2); chk_out("loss_hold_pre", 2, 0, 1, 0);
    step(1); chk_out("loss_hold", 0, 0, 0, 1);
    cmp("loss_bootsel_kept", int'(bootsel_o), 0);
    lock_i = 1'b1;
    step(3); chk_out("repeat_pwr", 1, 0, 0, 0);
    step(8); chk_out("repeat_hold", 2, 0, 1, 0);
    step(5); chk_out("repeat_run", 3, 1, 1, 0);
    cmp("repeat_bootsel1", int'(bootsel_o), 1);

    // Randomized pad activity, with one mid-run asynchronous reset
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) == 0) btn_i = ~btn_i;
      if (lock_i) begin
        if ($urandom_range(0, 79) == 0) lock_i = 1'b0;
      end else if ($urandom_range(0, 3) == 0) lock_i = 1'b1;
      if ($urandom_range(0, 7) == 0) boot_i = ~boot_i;
      if (i == 700) rst_n = 1'b0;
      if (i == 703) rst_n = 1'b1;
      step(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
